// File: rtl/pill_pkg.sv
// Shared types and BCD helpers for the pill feeder.
package pill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BOTTLE,
        DISPENSE,
        ADVANCE,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] l;
    } bcd2_t;

    function automatic logic bcd_valid(bcd2_t v);
        return (v.h <= 4'd9) && (v.l <= 4'd9) && (v != '0);
    endfunction

    function automatic bcd2_t bcd_inc(bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.l == 4'd9) begin
            r.l = 4'd0;
            r.h = (v.h == 4'd9) ? 4'd0 : v.h + 4'd1;
        end else begin
            r.l = v.l + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pill_feeder_if.sv
// Control, settings and display bundle between the line and the feeder.
interface pill_feeder_if;

    logic       start;
    logic       stop;
    logic [3:0] maxL;
    logic [3:0] maxH;
    logic [3:0] bot_maxL;
    logic [3:0] bot_maxH;
    logic       bottle_ready;
    logic       pill;
    logic       advance_req;
    logic [3:0] pillL;
    logic [3:0] pillH;
    logic [3:0] seqL;
    logic [3:0] seqH;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, maxL, maxH, bot_maxL, bot_maxH, bottle_ready,
        input  pill, advance_req, pillL, pillH, seqL, seqH, busy, done
    );

    modport slave (
        input  start, stop, maxL, maxH, bot_maxL, bot_maxH, bottle_ready,
        output pill, advance_req, pillL, pillH, seqL, seqH, busy, done
    );

endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, 00..99, synchronous clear has priority over inc.
module bcd_counter2
    import pill_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  clr,
    input  logic  inc,
    output bcd2_t value
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= bcd_inc(value);
        end
    end

endmodule

// File: rtl/pill_feeder.sv
// Chute controller: paced pill pulses per bottle, conveyor handshake,
// BCD pill/bottle counts and a programmed bottle limit.
module pill_feeder
    import pill_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4
) (
    input logic          CLK,
    input logic          RST,
    pill_feeder_if.slave bus
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    // One extra count while the bottle is missing, so the first edge that
    // sees it back starts the same full gap as after WAIT_BOTTLE.
    localparam logic [7:0] GAP_HOLD = 8'(GAP_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] gap_q, gap_d;
    bcd2_t      tgt_pill_q, tgt_pill_d;
    bcd2_t      tgt_bot_q, tgt_bot_d;
    logic       pill_q, pill_d;
    logic       adv_q, adv_d;
    logic       busy_q, done_q;

    logic       pill_clr, pill_inc;
    logic       seq_clr, seq_inc;
    bcd2_t      pill_cnt, seq_cnt;
    bcd2_t      set_pill, set_bot;
    logic       start_ok;

    assign set_pill = {bus.maxH, bus.maxL};
    assign set_bot  = {bus.bot_maxH, bus.bot_maxL};
    assign start_ok = bus.start && bcd_valid(set_pill)
                      && bcd_valid(set_bot);

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tgt_pill_d = tgt_pill_q;
        tgt_bot_d  = tgt_bot_q;
        pill_d     = 1'b0;
        adv_d      = 1'b0;
        pill_clr   = 1'b0;
        pill_inc   = 1'b0;
        seq_clr    = 1'b0;
        seq_inc    = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        tgt_pill_d = set_pill;
                        tgt_bot_d  = set_bot;
                        pill_clr   = 1'b1;
                        seq_clr    = 1'b1;
                        state_d    = WAIT_BOTTLE;
                    end
                end
                WAIT_BOTTLE: begin
                    if (bus.bottle_ready) begin
                        gap_d   = GAP_LOAD;
                        state_d = DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (pill_cnt == tgt_pill_q) begin
                        seq_inc = 1'b1;
                        if (bcd_inc(seq_cnt) == tgt_bot_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = ADVANCE;
                            adv_d   = 1'b1;
                        end
                    end else if (!bus.bottle_ready) begin
                        gap_d = GAP_HOLD;
                    end else if (gap_q == 8'd0) begin
                        pill_d   = 1'b1;
                        pill_inc = 1'b1;
                        gap_d    = GAP_LOAD;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                ADVANCE: begin
                    if (!bus.bottle_ready) begin
                        pill_clr = 1'b1;
                        state_d  = WAIT_BOTTLE;
                    end else begin
                        adv_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            tgt_pill_q <= '0;
            tgt_bot_q  <= '0;
            pill_q     <= 1'b0;
            adv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tgt_pill_q <= tgt_pill_d;
            tgt_bot_q  <= tgt_bot_d;
            pill_q     <= pill_d;
            adv_q      <= adv_d;
            busy_q     <= (state_d == WAIT_BOTTLE) || (state_d == DISPENSE)
                          || (state_d == ADVANCE);
            done_q     <= (state_d == DONE);
        end
    end

    bcd_counter2 u_pill_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (pill_clr),
        .inc   (pill_inc),
        .value (pill_cnt)
    );

    bcd_counter2 u_seq_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (seq_clr),
        .inc   (seq_inc),
        .value (seq_cnt)
    );

    assign bus.pill        = pill_q;
    assign bus.advance_req = adv_q;
    assign bus.pillL       = pill_cnt.l;
    assign bus.pillH       = pill_cnt.h;
    assign bus.seqL        = seq_cnt.l;
    assign bus.seqH        = seq_cnt.h;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: doc/pill_feeder.md
# pill_feeder

Dispense-side controller for the bottling line. It drives the chute that drops pills into the bottle under it: one `pill` pulse per pill, a fixed number of pills per bottle, and a conveyor-advance handshake between bottles. It keeps BCD pill and bottle counts for the display, and stops after a programmed number of bottles. It sits upstream of the pill/bottle counting logic and uses the same 2-digit BCD settings format (`maxL/maxH`, `bot_maxL/bot_maxH`).

## Interface

- `GAP_CYCLES`, default 4: cycles between successive `pill` pulses; legal range 1..255.

- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: begins a run; sampled only in IDLE and DONE.
- `stop` in 1: aborts the run from any state.
- `maxL`, `maxH` in 4 each: pills per bottle, BCD ones and tens.
- `bot_maxL`, `bot_maxH` in 4 each: bottles per run, BCD ones and tens.
- `bottle_ready` in 1: conveyor reports a bottle in place under the chute.
- `pill` out 1: one-cycle pulse that releases one pill.
- `advance_req` out 1: request to the conveyor to move the next bottle in.
- `pillL`, `pillH` out 4: BCD count of pills in the current bottle.
- `seqL`, `seqH` out 4: BCD count of bottles completed.
- `busy` out 1: high in WAIT_BOTTLE, DISPENSE and ADVANCE.
- `done` out 1: high in DONE.

## Operation

- States: IDLE, WAIT_BOTTLE, DISPENSE, ADVANCE, DONE.
- Reset drives state to IDLE and every output to 0, immediately and asynchronously.
- **IDLE:** on `start`, latch the four settings and check them.
  - Settings are invalid if any digit is greater than 9, or either 2-digit value is 00.
  - Invalid settings: ignore `start` and stay in IDLE.
  - Valid settings: clear all counters and go to WAIT_BOTTLE.
  - Settings inputs are ignored after latching; mid-run changes have no effect.
- **WAIT_BOTTLE:** when `bottle_ready`=1, load the gap counter with GAP_CYCLES−1 and go to DISPENSE.
- **DISPENSE:**
  - When the gap counter is 0 and `bottle_ready`=1: pulse `pill`, increment `pillL/pillH` (BCD, ones carry into tens), and reload the gap counter.
  - Otherwise, while `bottle_ready`=1, decrement the gap counter.
  - If `bottle_ready` drops: no pills, and the gap counter reloads. Dispensing resumes GAP_CYCLES cycles after `bottle_ready` returns.
  - On the cycle the pill count reaches the latched target, increment `seqL/seqH`. Then:
    - if the bottle count now equals the bottle target, go to DONE;
    - otherwise go to ADVANCE.
- **ADVANCE:** `advance_req`=1.
  - The conveyor acknowledges by dropping `bottle_ready`.
  - On the first cycle with `bottle_ready`=0: clear the pill count, drop `advance_req`, go to WAIT_BOTTLE.
- **DONE:** counts hold for display.
  - `start` begins a new run with the same checks as in IDLE.
  - `stop` goes to IDLE.
- **stop:** has priority over everything except reset.
  - From any state, next state is IDLE and `advance_req`=0.
  - No `pill` pulse in that cycle.
  - Counts hold their values.
- **Simultaneous `start` and `stop`:** `stop` wins.
- **Arithmetic:** counters are 2-digit BCD, 00..99.
  - The target comparison stops counting before 99, so counters never wrap.
  - `pill` never fires more times per bottle than the target.

## Timing

- All outputs are registered.
- `pill` is high for exactly one cycle, in the same cycle that `pillL/pillH` shows the incremented value.
- Latency, `start` sampled at edge k:
  - WAIT_BOTTLE after edge k.
  - With `bottle_ready` already high: DISPENSE after edge k+1.
  - First `pill` after edge k+1+GAP_CYCLES.
- Successive pills are GAP_CYCLES cycles apart. GAP_CYCLES=1 gives a pill every cycle.
- After the last pill of a bottle: ADVANCE (`advance_req`=1) or DONE (`done`=1) one cycle later.
- `advance_req` is held until the conveyor acknowledges; there is no timeout.

## Structure

- Shared package `pill_pkg` holds:
  - the state enum;
  - a `bcd2_t` typedef (two 4-bit digits);
  - a `bcd_valid` function (nonzero value, each digit ≤ 9).
- One sub-module, `bcd_counter2`: 2-digit BCD counter with synchronous `clr` and `inc`, asynchronous `RST`, and output value.
  - Instantiate twice: pill count and bottle count.
- Gap counter and FSM live in the top module.

## Test plan

- Reset mid-DISPENSE → all outputs 0 in the same cycle, IDLE; a following `start` behaves normally.
- GAP=4, `max`=03, `bot_max`=02, `bottle_ready` held high except while acknowledging `advance_req` → pills at cycles k+5, k+9, k+13, then `advance_req`; after acknowledgement and new bottle, 3 more pills; `seq`=02, `done`=1; exactly 6 `pill` pulses.
- `max`=12 → `pillL/pillH` steps 09→10→11→12, and `seq` increments once.
- `bottle_ready` dropped for 5 cycles in DISPENSE → no `pill` pulses in that window; next pill GAP_CYCLES cycles after it returns.
- `start` with `maxL`=A, or with `bot_max`=00 → stays in IDLE, `busy`=0, no pills.
- `stop` during ADVANCE → `advance_req`=0 and IDLE next cycle, counts held; `start`+`stop` together in IDLE → stays in IDLE.
